load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store unit for the RISC-V core, sitting between execute and the register file write port. It takes the ALU-computed address and rs2 store data, runs one request/grant/response transaction against data memory, and returns sign/zero-extended load data on the register file's `data_mem_data` input. While a transaction is in flight it raises `stall` so the core holds the PC and suppresses `reg_write`.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width.
- `DATA_W`, 32, data width; fixed at 32, with 4 byte lanes.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  execute presents a load or store.
- `req_ready`  out  1  LSU is idle and accepts this cycle; equal to (state==IDLE) & rst.
- `is_store`  in  1  1 = store, 0 = load.
- `funct3`  in  3  RV32I width/sign code.
- `addr`  in  32  byte address (ALU result).
- `store_data`  in  32  rs2 value.
- `mem_req`  out  1  memory request; held until granted.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  32  word-aligned address, {addr[31:2],2'b00}.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_gnt`  in  1  memory accepts request.
- `mem_rvalid`  in  1  read data valid, or write acknowledge.
- `mem_rdata`  in  32  raw read word.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `load_data`  out  32  extended load result; 0 for stores.
- `fault`  out  1  qualifies `rsp_valid`: misaligned access or illegal funct3.
- `stall`  out  1  1 in every state other than IDLE.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE:**
  - On req_valid & req_ready, the request is latched (is_store, funct3, addr[1:0], store_data).
  - Legal request → REQ. Faulting request → DONE with fault=1 and no memory access.
- **REQ:**
  - mem_req=1 with stable mem_we/addr/be/wdata.
  - mem_gnt & mem_rvalid → DONE.
  - mem_gnt alone → WAIT.
  - mem_rvalid without mem_gnt is ignored.
- **WAIT:** mem_req=0; mem_rvalid → DONE, latching mem_rdata.
- **DONE:** rsp_valid=1 for exactly one cycle, load_data/fault valid → IDLE.
- Stores also wait for mem_rvalid, which acts as the write ack. rdata is ignored and load_data=0.
- **Legal funct3:**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value → fault.
- **Byte enables:**
  - SB: 4'b0001<<addr[1:0].
  - SH: 4'b0011<<{addr[1],1'b0}.
  - SW: 4'b1111.
  - Loads: 4'b1111.
- **Write data:** SB {4{sd[7:0]}}, SH {2{sd[15:0]}}, SW sd.
- **Load extraction:** shift mem_rdata right by 8*addr[1:0], then take the low byte or halfword and sign-extend (LB/LH) or zero-extend (LBU/LHU). LW is passed through unchanged.
- req_valid while busy is ignored; upstream holds it.
- Outputs not listed as active in the current state are driven 0.

## Timing
- Reset (rst=0 at an edge):
  - state=IDLE.
  - mem_req, mem_we, rsp_valid, fault, stall = 0.
  - load_data = 0, mem_be = 0.
  - req_ready is 0 while rst is low.
- Reset mid-transaction aborts it: mem_req drops at that edge, and a later mem_rvalid arriving in IDLE is ignored.
- Best-case latency, with accept at edge 0:
  - mem_req is high in cycle 1.
  - Same-cycle gnt+rvalid → rsp_valid in cycle 2.
  - This gives 3 cycles total, with stall high in cycles 1–2.
- A fault path has rsp_valid in cycle 1 and never asserts mem_req.
- Back-to-back requests: a new request can be accepted in the cycle after DONE.
- load_data and fault hold their values until the next DONE.

## Configuration
- `LSU_MISALIGN_CHECK_EN`:
  - Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, fault as described above.
  - Undefined: no alignment fault. Low offset bits are forced to natural alignment (addr[0] cleared for halfwords, addr[1:0] cleared for words) before lane select and extraction.
  - Illegal funct3 faults in both builds.

## Structure
- Package `lsu_pkg`:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state typedef.
  - Byte-lane count constant.
- Sub-module `lsu_align`:
  - Purely combinational.
  - Computes mem_be, mem_wdata, the misalign/illegal flags, and load extraction from funct3, offset and data.
  - Instantiated once; the FSM and registers stay in load_store_unit.

## Test plan
- LW at addr 0x100, mem_rdata=0xDEADBEEF, gnt+rvalid in the same cycle → mem_addr 0x100, be 1111, rsp_valid 3 cycles after accept, load_data 0xDEADBEEF.
- LB at 0x103 and LBU at 0x103, rdata 0x80112233 → load_data 0xFFFFFF80 and 0x00000080 respectively.
- SH at 0x202, store_data 0x0000ABCD, gnt delayed 2 cycles then rvalid 3 cycles later → mem_req held 3 cycles, be 1100, wdata 0xABCDABCD, stall high throughout, load_data 0.
- LW at 0x101 with MACRO defined → no mem_req, rsp_valid+fault the next cycle. Without the macro → mem_addr 0x100, be 1111, no fault.
- funct3=011 load → fault; then rst=0 during WAIT of a following LW → mem_req/stall 0 after the edge, and a stray rvalid yields no rsp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants and types for the load/store unit
//
// Purpose: RV32I funct3 width/sign codes, LSU FSM state encoding and the
// byte-lane count used by load_store_unit and lsu_align.
// Ports: none (package).
package lsu_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering, fault flags and load extraction
//
// Purpose: purely combinational helper for load_store_unit. From funct3 and
// the low address bits it derives byte enables, lane-replicated write data,
// illegal/misaligned flags and the extended load result.
// Build option: LSU_MISALIGN_CHECK_EN enables misalignment faults; without it
// the offset is forced to natural alignment instead.
// Ports:
//   is_store_i    1 = store, 0 = load
//   funct3_i      RV32I width/sign code
//   offset_i      addr[1:0]
//   store_data_i  rs2 value
//   rdata_i       raw memory word
//   be_o          byte enables
//   wdata_o       lane-replicated store data (0 for loads)
//   illegal_o     funct3 not valid for this access type
//   misalign_o    offset not naturally aligned (check builds only)
//   load_data_o   sign/zero-extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic                 is_store_i,
  input  logic [2:0]           funct3_i,
  input  logic [1:0]           offset_i,
  input  logic [31:0]          store_data_i,
  input  logic [31:0]          rdata_i,
  output logic [NUM_LANES-1:0] be_o,
  output logic [31:0]          wdata_o,
  output logic                 illegal_o,
  output logic                 misalign_o,
  output logic [31:0]          load_data_o
);

  logic        is_half;
  logic        is_word;
  logic [1:0]  eff_off;
  logic [31:0] shifted;

  assign is_half = (funct3_i[1:0] == 2'b01);
  assign is_word = (funct3_i[1:0] == 2'b10);

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign_o = (is_half & offset_i[0]) | (is_word & (offset_i != 2'b00));
  assign eff_off    = offset_i;
`else
  // No alignment fault: drop the offset bits below the access size.
  assign misalign_o = 1'b0;
  assign eff_off    = is_word ? 2'b00 : (is_half ? {offset_i[1], 1'b0} : offset_i);
`endif

  always_comb begin
    illegal_o = 1'b0;
    if (is_store_i) begin
      illegal_o = !(funct3_i inside {F3_B, F3_H, F3_W});
    end else begin
      illegal_o = !(funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end
  end

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = '0;
    if (is_store_i) begin
      case (funct3_i)
        F3_B: begin
          be_o    = 4'b0001 << eff_off;
          wdata_o = {4{store_data_i[7:0]}};
        end
        F3_H: begin
          be_o    = 4'b0011 << {eff_off[1], 1'b0};
          wdata_o = {2{store_data_i[15:0]}};
        end
        F3_W: begin
          be_o    = 4'b1111;
          wdata_o = store_data_i;
        end
        default: ;
      endcase
    end
  end

  // Bring the addressed byte/halfword down to lane 0 before extending.
  assign shifted = rdata_i >> {eff_off, 3'b000};

  always_comb begin
    load_data_o = '0;
    case (funct3_i)
      F3_B:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    load_data_o = rdata_i;
      F3_BU:   load_data_o = {24'b0, shifted[7:0]};
      F3_HU:   load_data_o = {16'b0, shifted[15:0]};
      default: load_data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle RV32I load/store unit
//
// Purpose: accepts one load/store from execute, runs a req/gnt/rvalid
// transaction on data memory and returns extended load data with a one-cycle
// rsp_valid pulse. stall is high whenever the unit is not idle.
// Build option: LSU_MISALIGN_CHECK_EN (see lsu_align).
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   req_valid/req_ready            request handshake from execute
//   is_store, funct3, addr,
//   store_data                     request payload
//   mem_req/mem_we/mem_addr/
//   mem_be/mem_wdata               memory request, held until mem_gnt
//   mem_gnt, mem_rvalid, mem_rdata memory grant and response
//   rsp_valid, load_data, fault    completion pulse and result
//   stall                          core hold while busy
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 is_store,
  input  logic [2:0]           funct3,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    store_data,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [NUM_LANES-1:0] mem_be,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    load_data,
  output logic                 fault,
  output logic                 stall
);

  lsu_state_e           state_q;
  logic                 is_store_q;
  logic [2:0]           funct3_q;
  logic [1:0]           off_q;
  logic                 mem_req_q;
  logic                 mem_we_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [NUM_LANES-1:0] mem_be_q;
  logic [DATA_W-1:0]    mem_wdata_q;
  logic                 rsp_valid_q;
  logic [DATA_W-1:0]    load_data_q;
  logic                 fault_q;
  logic                 stall_q;

  logic                 idle;
  logic                 al_is_store;
  logic [2:0]           al_funct3;
  logic [1:0]           al_off;
  logic [NUM_LANES-1:0] al_be;
  logic [DATA_W-1:0]    al_wdata;
  logic                 al_illegal;
  logic                 al_misalign;
  logic [DATA_W-1:0]    al_load;
  logic [DATA_W-1:0]    rsp_data;

  assign idle      = (state_q == S_IDLE);
  assign req_ready = idle & rst;

  // One aligner serves both phases: live request fields while idle (lanes
  // and fault check), latched fields while busy (load extraction).
  assign al_is_store = idle ? is_store   : is_store_q;
  assign al_funct3   = idle ? funct3     : funct3_q;
  assign al_off      = idle ? addr[1:0]  : off_q;

  lsu_align u_align (
    .is_store_i   (al_is_store),
    .funct3_i     (al_funct3),
    .offset_i     (al_off),
    .store_data_i (store_data),
    .rdata_i      (mem_rdata),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .illegal_o    (al_illegal),
    .misalign_o   (al_misalign),
    .load_data_o  (al_load)
  );

  assign rsp_data = is_store_q ? '0 : al_load;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      is_store_q  <= 1'b0;
      funct3_q    <= '0;
      off_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      load_data_q <= '0;
      fault_q     <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            is_store_q <= is_store;
            funct3_q   <= funct3;
            off_q      <= addr[1:0];
            stall_q    <= 1'b1;
            if (al_illegal | al_misalign) begin
              state_q     <= S_DONE;
              rsp_valid_q <= 1'b1;
              fault_q     <= 1'b1;
              load_data_q <= '0;
            end else begin
              state_q     <= S_REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store;
              mem_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
              mem_be_q    <= al_be;
              mem_wdata_q <= al_wdata;
            end
          end
        end
        S_REQ: begin
          // rvalid without a grant is not a response to this request.
          if (mem_gnt) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            if (mem_rvalid) begin
              state_q     <= S_DONE;
              rsp_valid_q <= 1'b1;
              fault_q     <= 1'b0;
              load_data_q <= rsp_data;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            state_q     <= S_DONE;
            rsp_valid_q <= 1'b1;
            fault_q     <= 1'b0;
            load_data_q <= rsp_data;
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          stall_q     <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign load_data = load_data_q;
  assign fault     = fault_q;
  assign stall     = stall_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] load_data;
  logic        fault;
  logic        stall;

  int n_vec;
  int n_err;
  logic [31:0] last_ld;
  logic        last_ld_known;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .load_data  (load_data),
    .fault      (fault),
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts at a negedge with the unit idle; ends at the negedge after DONE.
  task automatic run_txn(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input int gnt_dly, input int rv_dly, input logic [31:0] rd,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd,
                         input logic [31:0] exp_ld, input logic exp_flt);
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    is_store   = st;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    @(negedge clk);
    req_valid = 1'b0;
    if (exp_flt) begin
      chk({tag, " f_memreq"}, 32'(mem_req), 32'd0);
      chk({tag, " f_rsp"}, 32'(rsp_valid), 32'd1);
      chk({tag, " f_fault"}, 32'(fault), 32'd1);
      chk({tag, " f_stall"}, 32'(stall), 32'd1);
      last_ld_known = 1'b0;
    end else begin
      if (last_ld_known) chk({tag, " ld_hold"}, load_data, last_ld);
      for (int i = 0; i < gnt_dly; i++) begin
        chk({tag, " req_wait"}, 32'(mem_req), 32'd1);
        chk({tag, " stall_req"}, 32'(stall), 32'd1);
        mem_rvalid = (i == 0);
        mem_rdata  = 32'hBAD0BAD0;
        @(negedge clk);
        mem_rvalid = 1'b0;
      end
      chk({tag, " req"}, 32'(mem_req), 32'd1);
      chk({tag, " we"}, 32'(mem_we), 32'(st));
      chk({tag, " maddr"}, mem_addr, {a[31:2], 2'b00});
      chk({tag, " be"}, 32'(mem_be), 32'(exp_be));
      if (st) chk({tag, " wdata"}, mem_wdata, exp_wd);
      chk({tag, " rsp_early"}, 32'(rsp_valid), 32'd0);
      mem_gnt    = 1'b1;
      mem_rvalid = (rv_dly == 0);
      mem_rdata  = rd;
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      for (int i = 0; i < rv_dly; i++) begin
        chk({tag, " wait_req"}, 32'(mem_req), 32'd0);
        chk({tag, " wait_stall"}, 32'(stall), 32'd1);
        chk({tag, " wait_rsp"}, 32'(rsp_valid), 32'd0);
        mem_rvalid = (i == rv_dly - 1);
        mem_rdata  = rd;
        @(negedge clk);
        mem_rvalid = 1'b0;
      end
      chk({tag, " rsp"}, 32'(rsp_valid), 32'd1);
      chk({tag, " fault"}, 32'(fault), 32'd0);
      chk({tag, " ld"}, load_data, exp_ld);
      chk({tag, " stall_done"}, 32'(stall), 32'd1);
      last_ld       = exp_ld;
      last_ld_known = 1'b1;
    end
    @(negedge clk);
    chk({tag, " rsp_pulse"}, 32'(rsp_valid), 32'd0);
    chk({tag, " stall_idle"}, 32'(stall), 32'd0);
    if (!exp_flt) chk({tag, " ld_keep"}, load_data, exp_ld);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    last_ld = '0;
    last_ld_known = 1'b0;
    rst = 1'b0;
    req_valid = 1'b0;
    is_store = 1'b0;
    funct3 = 3'b000;
    addr = '0;
    store_data = '0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;

    @(negedge clk);
    @(negedge clk);
    chk("rst ready", 32'(req_ready), 32'd0);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst rsp", 32'(rsp_valid), 32'd0);
    chk("rst fault", 32'(fault), 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst ld", load_data, 32'd0);
    chk("rst be", 32'(mem_be), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    last_ld_known = 1'b1;

    run_txn("lw100", 1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF,
            4'b1111, 32'h0, 32'hDEADBEEF, 1'b0);
    run_txn("lb103", 1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80112233,
            4'b1111, 32'h0, 32'hFFFFFF80, 1'b0);
    run_txn("lbu103", 1'b0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80112233,
            4'b1111, 32'h0, 32'h00000080, 1'b0);
    run_txn("sh202", 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 2, 3, 32'h12345678,
            4'b1100, 32'hABCDABCD, 32'h0, 1'b0);
    run_txn("lh102", 1'b0, 3'b001, 32'h102, 32'h0, 1, 1, 32'h80017FFF,
            4'b1111, 32'h0, 32'hFFFF8001, 1'b0);
    run_txn("lhu100", 1'b0, 3'b101, 32'h100, 32'h0, 0, 2, 32'h8001F00D,
            4'b1111, 32'h0, 32'h0000F00D, 1'b0);
    run_txn("sb101", 1'b1, 3'b000, 32'h101, 32'h1234565A, 0, 0, 32'hFFFFFFFF,
            4'b0010, 32'h5A5A5A5A, 32'h0, 1'b0);
    run_txn("sw30c", 1'b1, 3'b010, 32'h30C, 32'hCAFEF00D, 1, 0, 32'h0,
            4'b1111, 32'hCAFEF00D, 32'h0, 1'b0);
`ifdef LSU_MISALIGN_CHECK_EN
    run_txn("lw101", 1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h11223344,
            4'b1111, 32'h0, 32'h0, 1'b1);
    run_txn("sh201", 1'b1, 3'b001, 32'h201, 32'h0000ABCD, 0, 0, 32'h0,
            4'b0110, 32'hABCDABCD, 32'h0, 1'b1);
`else
    run_txn("lw101", 1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h11223344,
            4'b1111, 32'h0, 32'h11223344, 1'b0);
    run_txn("lh103", 1'b0, 3'b001, 32'h103, 32'h0, 0, 0, 32'h9ABC5678,
            4'b1111, 32'h0, 32'hFFFF9ABC, 1'b0);
`endif
    run_txn("ld011", 1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0,
            4'b1111, 32'h0, 32'h0, 1'b1);
    run_txn("st100", 1'b1, 3'b100, 32'h100, 32'h0, 0, 0, 32'h0,
            4'b1111, 32'h0, 32'h0, 1'b1);

    // Reset while waiting for rvalid, then a stray rvalid in IDLE.
    req_valid = 1'b1;
    is_store  = 1'b0;
    funct3    = 3'b010;
    addr      = 32'h300;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("abort wait_stall", 32'(stall), 32'd1);
    chk("abort wait_req", 32'(mem_req), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort req_after", 32'(mem_req), 32'd0);
    chk("abort stall_after", 32'(stall), 32'd0);
    chk("abort ready_in_rst", 32'(req_ready), 32'd0);
    rst = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55555555;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("abort stray_rsp", 32'(rsp_valid), 32'd0);
    chk("abort ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("abort stray_rsp2", 32'(rsp_valid), 32'd0);
    chk("abort ld", load_data, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
